pattern_gen: RTL

//  Parametrised multi-channel test-pattern generator: the stimulus source that drives ILA probes in example designs.

---
 rtl/pattern_gen_pkg.sv | 57 +++++
 rtl/pattern_gen_channel.sv | 79 +++++++
 rtl/pattern_gen.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pattern_gen_pkg.sv
// Shared types and LFSR tap table for the multi-channel test-pattern generator.
package pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_WALK = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    // Maximal-length XOR masks for a Galois right-shift LFSR, widths 2..32.
    function automatic logic [31:0] taps_for(input int width);
        logic [31:0] t;
        case (width)
            2:       t = 32'h0000_0003;
            3:       t = 32'h0000_0006;
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0829;
            13:      t = 32'h0000_100D;
            14:      t = 32'h0000_2015;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_D008;
            17:      t = 32'h0001_2000;
            18:      t = 32'h0002_0400;
            19:      t = 32'h0004_0023;
            20:      t = 32'h0009_0000;
            21:      t = 32'h0014_0000;
            22:      t = 32'h0030_0000;
            23:      t = 32'h0042_0000;
            24:      t = 32'h00E1_0000;
            25:      t = 32'h0120_0000;
            26:      t = 32'h0200_0023;
            27:      t = 32'h0400_0013;
            28:      t = 32'h0900_0000;
            29:      t = 32'h1400_0000;
            30:      t = 32'h2000_0029;
            31:      t = 32'h4800_0000;
            32:      t = 32'h8020_0003;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pattern_gen_channel.sv
// One pattern channel: holds mode, seed and current value; advances on tick.
// A config write in the same cycle as a tick takes priority and suppresses wrap.
module pattern_gen_channel
    import pattern_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             wr,
    input  mode_t            wr_mode,
    input  logic [WIDTH-1:0] wr_seed,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(taps_for(WIDTH));

    mode_t            mode_q;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] next_v;
    logic [WIDTH-1:0] wr_val;
    logic             wrap_c;

    always_comb begin
        next_v = value_q;
        wrap_c = 1'b0;
        case (mode_q)
            MODE_UP: begin
                next_v = value_q + 1'b1;
                wrap_c = &value_q;
            end
            MODE_DOWN: begin
                next_v = value_q - 1'b1;
                wrap_c = (value_q == '0);
            end
            MODE_LFSR: begin
                next_v = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
                wrap_c = (next_v == seed_q);
            end
            MODE_WALK: begin
                // An all-zero value would never walk; restart from bit 0.
                if (value_q == '0) begin
                    next_v = WIDTH'(1);
                end else begin
                    next_v = {value_q[WIDTH-2:0], value_q[WIDTH-1]};
                    wrap_c = value_q[WIDTH-1];
                end
            end
            default: begin
                next_v = value_q;
                wrap_c = 1'b0;
            end
        endcase
    end

    // LFSR lockup guard: the all-zero state is a fixed point.
    assign wr_val = ((wr_mode == MODE_LFSR) && (wr_seed == '0)) ? WIDTH'(1) : wr_seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_UP;
            seed_q  <= '0;
            value_q <= '0;
        end else if (wr) begin
            mode_q  <= wr_mode;
            seed_q  <= wr_val;
            value_q <= wr_val;
        end else if (tick) begin
            value_q <= next_v;
        end
    end

    assign value = value_q;
    assign wrap  = tick & ~wr & wrap_c;

endmodule

// File: rtl/pattern_gen.sv
// Multi-channel test-pattern generator: run-control FSM, prescaler, config decode.
// Optional burst mode (burst_len/done ports) is enabled by defining PATTERN_GEN_BURST_EN.
//
// state | meaning
// IDLE  | stopped, waiting for start or step
// RUN   | ticking every prescale+1 cycles until stop (or burst end)
// STEP  | one forced tick, then back to IDLE
module pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int  WIDTH      = 8,
    parameter int  CHANNELS   = 4,
    parameter int  PRESCALE_W = 16,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      step,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [CH_W-1:0]           cfg_chan,
    input  logic [1:0]                cfg_mode,
    input  logic [WIDTH-1:0]          cfg_seed,
`ifdef PATTERN_GEN_BURST_EN
    input  logic [15:0]               burst_len,
    output logic                      done,
`endif
    output logic [CHANNELS*WIDTH-1:0] data,
    output logic                      data_valid,
    output logic [CHANNELS-1:0]       wrap,
    output logic                      busy
);

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  tick;
    logic                  burst_last;
    logic                  cfg_wr;
    logic [CHANNELS-1:0]   wr_c;
    logic [CHANNELS-1:0]   wrap_c;
    logic [CHANNELS-1:0]   wrap_q;
    logic                  data_valid_q;

`ifdef PATTERN_GEN_BURST_EN
    logic [15:0] burst_len_q;
    logic [15:0] burst_cnt_q;
    logic        done_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        tick       = 1'b0;
        burst_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                // >= so that lowering prescale below the count ticks at once.
                tick  = (cnt_q >= prescale);
                cnt_d = tick ? '0 : cnt_q + 1'b1;
`ifdef PATTERN_GEN_BURST_EN
                burst_last = tick && (burst_len_q != 16'd0) &&
                             (burst_cnt_q == burst_len_q - 16'd1);
                if (burst_last) begin
                    state_d = IDLE;
                end
`endif
            end
            STEP: begin
                tick    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            data_valid_q <= 1'b0;
            wrap_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_valid_q <= tick;
            wrap_q       <= wrap_c;
        end
    end

`ifdef PATTERN_GEN_BURST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_len_q <= '0;
            burst_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= burst_last;
            if ((state_q == IDLE) && start && !stop) begin
                burst_len_q <= burst_len;
                burst_cnt_q <= '0;
            end else if ((state_q == RUN) && tick) begin
                burst_cnt_q <= burst_cnt_q + 16'd1;
            end
        end
    end

    assign done = done_q;
`endif

    assign cfg_ready = 1'b1;
    assign cfg_wr    = cfg_valid & cfg_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        // Out-of-range channel numbers simply match no channel.
        assign wr_c[c] = cfg_wr && (cfg_chan == CH_W'(c));

        pattern_gen_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .wr      (wr_c[c]),
            .wr_mode (mode_t'(cfg_mode)),
            .wr_seed (cfg_seed),
            .value   (data[c*WIDTH +: WIDTH]),
            .wrap    (wrap_c[c])
        );
    end

    assign data_valid = data_valid_q;
    assign wrap       = wrap_q;
    assign busy       = (state_q != IDLE);

    // Silences the unused-bit case where burst mode is compiled out.
    logic unused_ok;
    assign unused_ok = burst_last;

endmodule
